// File: rtl/delay_sum_engine.sv
// delay_sum_engine
//   Delay-and-sum engine. For each output point t of a frame it looks up a
//   per-channel delay, reads the delayed sample of every channel, sums the
//   samples in a guard-bit accumulator and hands the sum to a ready/valid sink.
//
//   Ports
//     clk        sole clock, rising edge
//     reset_n    asynchronous active-low reset
//     start      frame start pulse (ignored while busy or on the done cycle)
//     busy       frame in progress
//     done       one-cycle end-of-frame pulse
//     dly_rd_en  delay-table read strobe, dly_addr = ch*OUT_LEN + t
//     dly_data   delay value, valid one cycle after dly_rd_en
//     smp_rd_en  sample-memory read strobe, smp_addr = {ch, delay}
//     smp_data   signed sample, valid one cycle after smp_rd_en
//     out_valid  output word valid; out_data/out_idx/out_last stable while high
//     out_ready  sink accepts the word on an edge where out_valid is high
//     out_data   signed channel sum
//     out_idx    output point index t
//     out_last   high with the final point of the frame
//
//   Build option
//     DSE_SATURATE_EN  defined: out_data is the sum saturated to OUT_W bits;
//                      undefined: out_data is the low OUT_W bits of the sum.
//     Both builds are identical when OUT_W covers the accumulator width.
module delay_sum_engine #(
    parameter int NUM_CH  = 8,
    parameter int OUT_LEN = 768,
    parameter int SMP_W   = 32,
    parameter int SMP_AW  = 13,
    parameter int DLY_AW  = 13,
    parameter int OUT_W   = 40
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic                                dly_rd_en,
    output logic [DLY_AW-1:0]                   dly_addr,
    input  logic [SMP_AW-1:0]                   dly_data,
    output logic                                smp_rd_en,
    output logic [SMP_AW+$clog2(NUM_CH)-1:0]    smp_addr,
    input  logic signed [SMP_W-1:0]             smp_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [OUT_W-1:0]             out_data,
    output logic [$clog2(OUT_LEN)-1:0]          out_idx,
    output logic                                out_last
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int IDX_W = $clog2(OUT_LEN);
    localparam int ACC_W = SMP_W + CH_W;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_DLY = 3'd1,
        RD_SMP = 3'd2,
        ACC    = 3'd3,
        EMIT   = 3'd4
    } state_t;

    state_t                   state, state_nxt;
    logic [CH_W-1:0]          ch, ch_nxt;
    logic [IDX_W-1:0]         t, t_nxt;
    logic signed [ACC_W-1:0]  acc, acc_nxt;
    logic                     done_nxt;
    logic signed [OUT_W-1:0]  acc_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ch    <= '0;
            t     <= '0;
            acc   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            ch    <= ch_nxt;
            t     <= t_nxt;
            acc   <= acc_nxt;
            done  <= done_nxt;
        end
    end

    // Sum to output width: sign-extend when wide enough, otherwise wrap or clamp.
    generate
        if (OUT_W >= ACC_W) begin : g_wide
            assign acc_out = OUT_W'(acc);
        end else begin : g_narrow
`ifdef DSE_SATURATE_EN
            // In range when all bits from the output sign bit upward agree.
            always_comb begin
                if (acc[ACC_W-1:OUT_W-1] == {(ACC_W-OUT_W+1){acc[ACC_W-1]}})
                    acc_out = acc[OUT_W-1:0];
                else if (acc[ACC_W-1])
                    acc_out = {1'b1, {(OUT_W-1){1'b0}}};
                else
                    acc_out = {1'b0, {(OUT_W-1){1'b1}}};
            end
`else
            assign acc_out = acc[OUT_W-1:0];
`endif
        end
    endgenerate

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        t_nxt     = t;
        acc_nxt   = acc;
        done_nxt  = 1'b0;
        dly_rd_en = 1'b0;
        dly_addr  = '0;
        smp_rd_en = 1'b0;
        smp_addr  = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_idx   = '0;
        out_last  = 1'b0;

        case (state)
            IDLE: begin
                // done is high only on the cycle after the final transfer,
                // so gating with it drops a start that coincides with it.
                if (start && !done) begin
                    t_nxt     = '0;
                    ch_nxt    = '0;
                    acc_nxt   = '0;
                    state_nxt = RD_DLY;
                end
            end
            RD_DLY: begin
                dly_rd_en = 1'b1;
                dly_addr  = DLY_AW'(ch) * DLY_AW'(OUT_LEN) + DLY_AW'(t);
                state_nxt = RD_SMP;
            end
            RD_SMP: begin
                smp_rd_en = 1'b1;
                smp_addr  = {ch, dly_data};
                state_nxt = ACC;
            end
            ACC: begin
                acc_nxt = acc + {{CH_W{smp_data[SMP_W-1]}}, smp_data};
                if (ch == CH_W'(NUM_CH - 1)) begin
                    state_nxt = EMIT;
                end else begin
                    ch_nxt    = ch + CH_W'(1);
                    state_nxt = RD_DLY;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                out_data  = acc_out;
                out_idx   = t;
                out_last  = (t == IDX_W'(OUT_LEN - 1));
                if (out_ready) begin
                    if (t == IDX_W'(OUT_LEN - 1)) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        t_nxt     = t + IDX_W'(1);
                        ch_nxt    = '0;
                        acc_nxt   = '0;
                        state_nxt = RD_DLY;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/delay_sum_engine.md
DELAY_SUM_ENGINE -- requirements
Module: delay_sum_engine

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NUM_CH, 8, channels summed per output point.
- OUT_LEN, 768, output points per frame.
- SMP_W, 32, signed sample width.
- SMP_AW, 13, per-channel sample address width.
- DLY_AW, 13, delay-table address width.
- OUT_W, 40, signed output width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- start, in, 1, frame start pulse.
- busy, out, 1, frame in progress.
- done, out, 1, one-cycle end-of-frame pulse.
- dly_rd_en, out, 1, delay-table read strobe.
- dly_addr, out, DLY_AW, delay-table address.
- dly_data, in, SMP_AW, delay value, valid 1 cycle after strobe.
- smp_rd_en, out, 1, sample-memory read strobe.
- smp_addr, out, SMP_AW+clog2(NUM_CH), sample address {ch, offset}.
- smp_data, in, SMP_W, signed sample, valid 1 cycle after strobe.
- out_valid, out, 1, output word valid.
- out_ready, in, 1, sink accepts word.
- out_data, out, OUT_W, signed channel sum.
- out_idx, out, clog2(OUT_LEN), output point index.
- out_last, out, 1, high with the final point (idx OUT_LEN-1).
REQ-003 Clock and reset SHALL be decided as: one clock; reset is asynchronous and active-low.

Function
REQ-004 FSM states SHALL be IDLE, RD_DLY, RD_SMP, ACC, EMIT.
REQ-005 IDLE: start=1 SHALL clear t, ch and acc, set busy and go to RD_DLY; start while busy SHALL be ignored.
REQ-006 RD_DLY SHALL assert dly_rd_en for one cycle with dly_addr = ch*OUT_LEN + t, then go to RD_SMP.
REQ-007 RD_SMP SHALL assert smp_rd_en with smp_addr = {ch, dly_data}, then go to ACC.
REQ-008 ACC SHALL add sign-extended smp_data to acc.
- ch < NUM_CH-1: increment ch, go to RD_DLY.
- otherwise: go to EMIT.
REQ-009 The accumulator SHALL be SMP_W+clog2(NUM_CH) bits, so that no intermediate overflow occurs.
REQ-010 EMIT SHALL hold out_valid=1 with out_data, out_idx=t and out_last stable until out_ready=1; the transfer SHALL occur on the edge where both are high.
REQ-011 After transfer:
- t < OUT_LEN-1: increment t, clear ch and acc, go to RD_DLY.
- otherwise: pulse done, clear busy, go to IDLE.
REQ-012 With out_ready held high, each point SHALL take exactly 3*NUM_CH+1 cycles, i.e. 25 cycles at the default.
REQ-013 dly_rd_en and smp_rd_en SHALL be low in every state other than those above.
REQ-014 A start coincident with the done cycle SHALL be ignored.

Reset
REQ-015 reset_n low SHALL immediately force IDLE and drive the following low/zero: busy, done, dly_rd_en, smp_rd_en, out_valid, out_last, out_data, out_idx, dly_addr, smp_addr, acc, t, ch.
REQ-016 Reset mid-frame SHALL abandon the frame with no done pulse; operation SHALL resume only on a new start after reset_n rises.

Configuration
REQ-017 Macro DSE_SATURATE_EN:
- defined: out_data SHALL be acc saturated to the signed OUT_W range.
- undefined: out_data SHALL be the low OUT_W bits of acc (two's-complement wrap).
- when OUT_W >= accumulator width, both builds SHALL be identical.

Verification
REQ-018 Sample memory filled with smp = ch*1000 + offset, delay table all 5, start, ready=1 -> 768 outputs, each 28040, out_last on idx 767, done one cycle after the final transfer, 19200 cycles start-to-done.
REQ-019 Channel c delay = t+c at point t -> out_data at idx t = sum over c of (1000c + t + c).
REQ-020 out_ready low for 10 cycles at idx 3 -> out_valid, out_data and out_idx held constant; no read strobes during the hold; flow resumes without loss.
REQ-021 OUT_W=32, all samples 0x7FFFFFFF -> DSE_SATURATE_EN defined gives 0x7FFFFFFF; undefined gives 0xFFFFFFF8.
REQ-022 reset_n low at idx 400 mid-ACC -> all outputs zero asynchronously, no done; a new start replays from idx 0 with correct sums.
REQ-023 start pulsed while busy and on the done cycle -> frame unaffected, no second frame begins.
